// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract tile: FSM encoding,
// uio bit positions and the carry majority helper.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // uio_in control bits
  localparam int BIT_LOAD_A = 0;
  localparam int BIT_LOAD_B = 1;
  localparam int BIT_START  = 2;
  localparam int BIT_SUB    = 3;
  // uio_out status bits
  localparam int BIT_BUSY   = 4;
  localparam int BIT_DONE   = 5;
  localparam int BIT_COUT   = 6;
  localparam int BIT_OVF    = 7;

  localparam logic [7:0] UIO_OE_MASK = 8'hF0;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One full-adder bit with its carry flop. The carry is seeded on init
// (0 for add, 1 for subtract) and otherwise advances once per enabled cycle.
module serial_fa_cell
  import serial_addsub_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic init,
  input  logic cin_init,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);

  logic carry_q;
  logic carry_d;

  // Next carry: seed value at init, majority of the current bit otherwise.
  always_comb begin
    carry_d = carry_q;
    if (init) carry_d = cin_init;
    else      carry_d = maj3(a, b, carry_q);
  end

  // Carry flop, frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  carry_q <= 1'b0;
    else if (en) carry_q <= carry_d;
  end

  assign s     = a ^ b ^ carry_q;
  assign carry = carry_q;

endmodule

// File: rtl/tt_um_serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor tile. Operands load over ui_in,
// one result bit is produced per enabled clock, LSB first.
// Optional build macro SERIAL_ADDSUB_SAT_EN: saturate the result on signed
// overflow instead of wrapping.
module tt_um_serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q, wa_q, wb_q, res_q;
  logic [CNT_W-1:0]   bitcnt_q;
  logic               sub_q, amsb_q, bmsb_q;
  logic [7:0]         uo_q;
  logic               cout_q, ovf_q;

  logic               load_ok, start_acc, running, last_bit;
  logic [WIDTH-1:0]   b_eff, res_fin, res_out;
  logic               fa_s, fa_carry, carry_fin, ovf_fin;
  logic               unused_in;

  // Loads and starts are honoured only outside RUN and only while enabled.
  assign load_ok   = ena && (state_q != RUN);
  assign start_acc = load_ok && uio_in[BIT_START];
  assign running   = ena && (state_q == RUN);
  assign last_bit  = (bitcnt_q == CNT_W'(WIDTH - 1));
  assign b_eff     = uio_in[BIT_SUB] ? ~b_q : b_q;

  serial_fa_cell u_fa (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (start_acc | running),
    .init     (start_acc),
    .cin_init (uio_in[BIT_SUB]),
    .a        (wa_q[0]),
    .b        (wb_q[0]),
    .s        (fa_s),
    .carry    (fa_carry)
  );

  // Carry out of the final bit, and the completed result word on the last RUN cycle.
  assign carry_fin = maj3(wa_q[0], wb_q[0], fa_carry);
  assign res_fin   = {fa_s, res_q[WIDTH-1:1]};
  assign ovf_fin   = (amsb_q == bmsb_q) && (fa_s != amsb_q);

  // Result selection: wrap-around, or clamp toward the operand sign on overflow.
  always_comb begin
    res_out = res_fin;
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf_fin) begin
      res_out = amsb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; ena gating is already folded into start_acc/running.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start_acc)            state_d = RUN;
      RUN:        if (running && last_bit)  state_d = DONE;
      default:                              state_d = IDLE;
    endcase
  end

  // FSM outputs and fixed pad directions.
  always_comb begin
    uio_out           = 8'h00;
    uio_out[BIT_BUSY] = (state_q == RUN);
    uio_out[BIT_DONE] = (state_q == DONE);
    uio_out[BIT_COUT] = cout_q;
    uio_out[BIT_OVF]  = ovf_q;
    uo_out            = uo_q;
    uio_oe            = UIO_OE_MASK;
  end

  // Operand hold regs, serial shift regs, bit counter and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      res_q    <= '0;
      bitcnt_q <= '0;
      sub_q    <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      uo_q     <= 8'h00;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (load_ok && uio_in[BIT_LOAD_A]) a_q <= ui_in[WIDTH-1:0];
      if (load_ok && uio_in[BIT_LOAD_B]) b_q <= ui_in[WIDTH-1:0];
      if (start_acc) begin
        // Uses the pre-load operand values even if a load happens this cycle.
        sub_q    <= uio_in[BIT_SUB];
        wa_q     <= a_q;
        wb_q     <= b_eff;
        amsb_q   <= a_q[WIDTH-1];
        bmsb_q   <= b_eff[WIDTH-1];
        bitcnt_q <= '0;
      end else if (running) begin
        wa_q     <= wa_q >> 1;
        wb_q     <= wb_q >> 1;
        res_q    <= res_fin;
        bitcnt_q <= bitcnt_q + CNT_W'(1);
        if (last_bit) begin
          uo_q   <= 8'(res_out);
          cout_q <= sub_q ? ~carry_fin : carry_fin;
          ovf_q  <= ovf_fin;
        end
      end
    end
  end

  assign unused_in = ^{ui_in, uio_in[7:4]};

endmodule

// File: tb/tb_tt_um_serial_addsub.sv
// Directed plus random checks of the bit-serial add/subtract tile against a
// plain-arithmetic reference model.
module tb_tt_um_serial_addsub;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_vec = 0;
  int n_err = 0;

  tt_um_serial_addsub #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, result} for an 8-bit add or subtract.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    logic [8:0] full;
    logic [7:0] r;
    logic       c, v;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[7:0];
      c    = full[8];
      v    = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r = a - b;
      c = (a < b);
      v = (a[7] != b[7]) && (r[7] != a[7]);
    end
`ifdef SERIAL_ADDSUB_SAT_EN
    if (v) r = a[7] ? 8'h80 : 8'h7F;
`endif
    return {v, c, r};
  endfunction

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    ui_in = a; uio_in = 8'h01; @(negedge clk);
    ui_in = b; uio_in = 8'h02; @(negedge clk);
    ui_in = 8'h00; uio_in = 8'h00;
  endtask

  task automatic start_op(input logic sub);
    uio_in = {4'h0, sub, 3'b100};
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  // Waits (bounded) for done, then checks latency and result against the model.
  task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                           input int exp_cyc, input string tag);
    logic [9:0] e;
    int cyc;
    cyc = 0;
    while (uio_out[5] !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    e = model(a, b, sub);
    check({tag, "_lat"},  cyc,        exp_cyc);
    check({tag, "_res"},  uo_out,     e[7:0]);
    check({tag, "_cout"}, uio_out[6], e[8]);
    check({tag, "_ovf"},  uio_out[7], e[9]);
    check({tag, "_busy"}, uio_out[4], 1'b0);
    check({tag, "_oe"},   uio_oe,     8'hF0);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input bit do_load, input string tag);
    if (do_load) load_ab(a, b);
    start_op(sub);
    check({tag, "_busy0"}, uio_out[5:4], 2'b01);
    finish_op(a, b, sub, 8, tag);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;

    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    check("rst_uo",  uo_out,  8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe",  uio_oe,  8'hF0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases
    run_op(8'h35, 8'h0C, 1'b0, 1'b1, "t1_add");
    check("t1_uo_lit", uo_out, 8'h41);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, "t2_wrap");
    run_op(8'h7F, 8'h01, 1'b0, 1'b1, "t3_ovf");
    run_op(8'h80, 8'hFF, 1'b0, 1'b1, "t3_negovf");
    run_op(8'h10, 8'h20, 1'b1, 1'b1, "t4_sub");
    run_op(8'h10, 8'h20, 1'b0, 1'b0, "t4_restart");
    check("t4_uo_lit", uo_out, 8'h30);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, "t4_subovf");

    // Loads/start during RUN have no effect
    load_ab(8'h35, 8'h0C);
    start_op(1'b0);
    @(negedge clk);
    ui_in = 8'hAA; uio_in = 8'h0F;
    @(negedge clk);
    ui_in = 8'h00; uio_in = 8'h00;
    finish_op(8'h35, 8'h0C, 1'b0, 6, "t5_ignore");
    run_op(8'h35, 8'h0C, 1'b0, 1'b0, "t5_hold");

    // Load in DONE keeps done set
    ui_in = 8'h22; uio_in = 8'h01;
    @(negedge clk);
    uio_in = 8'h00;
    check("t5_done_after_load", uio_out[5], 1'b1);

    // Asynchronous reset in the middle of RUN
    load_ab(8'h35, 8'h0C);
    start_op(1'b0);
    repeat (3) @(negedge clk);
    check("t5_pre_rst_busy", uio_out[4], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_uo",  uo_out,  8'h00);
    check("t5_rst_uio", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_idle_uio", uio_out, 8'h00);

    // ena low mid-RUN freezes everything
    load_ab(8'h35, 8'h0C);
    start_op(1'b0);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    uio_in = 8'h0F; ui_in = 8'h99;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_frozen_busy", uio_out[5:4], 2'b01);
      check("t6_frozen_oe",   uio_oe,       8'hF0);
    end
    uio_in = 8'h00; ui_in = 8'h00;
    ena = 1'b1;
    finish_op(8'h35, 8'h0C, 1'b0, 5, "t6_pause");

    // Random operands and operations
    for (int k = 0; k < 24; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      run_op(ra, rb, rs, 1'b1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
